// File: rtl/qar_irq_ctrl.sv
// -----------------------------------------------------------------------------
// qar_irq_ctrl
//
// External interrupt controller feeding qar_core's irq_external /
// irq_external_ack pair. It aggregates NUM_SRC asynchronous peripheral
// interrupt lines, latches pending events and applies a software enable mask.
// A non-nested claim/complete handshake tells the handler which source fired
// and lets it retire that source.
//
// Parameters:
//   NUM_SRC    number of sources (1..31); source IDs are 1..NUM_SRC, 0 = none
//   EDGE_MASK  per-source trigger mode, 1 = rising edge, 0 = level high
//
// Ports:
//   clk               single clock, rising edge
//   rst_n             synchronous active-low reset
//   src_irq           raw asynchronous peripheral interrupt lines
//   reg_valid/reg_we  register access request / write strobe
//   reg_addr          byte address, word offset taken from [4:2]
//   reg_wdata         write data
//   reg_ready         access complete (zero wait states, follows reg_valid)
//   reg_rdata         read data (0 unless a read is presented)
//   irq_external      interrupt request to the core
//   irq_external_ack  acknowledge level from the core, rising edge = claim
//
// Register map (word offset):
//   0 PENDING   read bitmap, write-1-to-clear
//   1 ENABLE    read/write mask
//   2 CLAIM     read-only ID of the source in service, 0 if none
//   3 COMPLETE  write the in-service ID to retire it
//   4 INSERVICE read-only in-service bitmap
//   5..7        read 0, writes ignored
// -----------------------------------------------------------------------------
module qar_irq_ctrl #(
   parameter int                 NUM_SRC   = 8,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic               reg_valid,
   input  logic               reg_we,
   input  logic [31:0]        reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic               reg_ready,
   output logic [31:0]        reg_rdata,
   output logic               irq_external,
   input  logic               irq_external_ack
);

   localparam logic [NUM_SRC-1:0] ZERO_SRC       = {NUM_SRC{1'b0}};
   localparam logic [2:0]         ADDR_PENDING   = 3'd0;
   localparam logic [2:0]         ADDR_ENABLE    = 3'd1;
   localparam logic [2:0]         ADDR_CLAIM     = 3'd2;
   localparam logic [2:0]         ADDR_COMPLETE  = 3'd3;
   localparam logic [2:0]         ADDR_INSERVICE = 3'd4;

   // Registered state
   logic [NUM_SRC-1:0] s1_q, s1_d;
   logic [NUM_SRC-1:0] s2_q, s2_d;
   logic [NUM_SRC-1:0] s3_q, s3_d;
   logic               ack_q, ack_d;
   logic [1:0]         warm_q, warm_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] inservice_q, inservice_d;
   logic [4:0]         claim_q, claim_d;

   // Combinational helpers
   logic [NUM_SRC-1:0] eligible_s;
   logic               irq_req_s;
   logic               wr_s;
   logic [2:0]         addr_s;
   logic               claim_fire_s;
   logic               complete_s;
   logic               win_found_s;
   logic [4:0]         win_id_s;
   logic [NUM_SRC-1:0] win_onehot_s;
   logic [NUM_SRC-1:0] claim_bits_s;
   logic [NUM_SRC-1:0] edge_set_s;
   logic [NUM_SRC-1:0] level_set_s;
   logic [NUM_SRC-1:0] w1c_s;
   logic               unused_s;

   assign unused_s = ^{reg_addr[31:5], reg_addr[1:0]};

   assign wr_s       = reg_valid && reg_we;
   assign addr_s     = reg_addr[4:2];
   assign eligible_s = pending_q & enable_q;

   // Requests are only raised when nothing is in service (non-nested claims);
   // held low while reset is asserted, even before the first reset edge.
   assign irq_req_s    = rst_n && (|eligible_s) && (inservice_q == ZERO_SRC);
   assign irq_external = irq_req_s;
   assign reg_ready    = reg_valid;

   // A claim needs a fresh ack rising edge while a request is being presented.
   assign claim_fire_s = irq_external_ack && !ack_q && irq_req_s;

   // COMPLETE only retires the ID currently in service; anything else is dropped.
   assign complete_s = wr_s && (addr_s == ADDR_COMPLETE) && (claim_q != 5'd0) &&
                       (reg_wdata == {27'd0, claim_q});

   // Lowest-index eligible source wins the claim.
   always_comb begin
      win_found_s  = 1'b0;
      win_id_s     = 5'd0;
      win_onehot_s = ZERO_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible_s[i] && !win_found_s) begin
            win_found_s     = 1'b1;
            win_id_s        = 5'(i + 1);
            win_onehot_s[i] = 1'b1;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state logic for synchronizers, pending, enable and claim state.
   always_comb begin
      s1_d  = src_irq;
      s2_d  = s1_q;
      s3_d  = s2_q;
      ack_d = irq_external_ack;

      // warm_q counts the post-reset edges until s3 holds real samples; the
      // reset-cleared pipeline must not look like a rising edge on a line that
      // was already high.
      warm_d = (warm_q == 2'd3) ? 2'd3 : (warm_q + 2'd1);

      claim_bits_s = claim_fire_s ? win_onehot_s : ZERO_SRC;
      edge_set_s   = (warm_q == 2'd3) ? (s2_q & ~s3_q & EDGE_MASK) : ZERO_SRC;
      // A level source being claimed this edge counts as in service, otherwise
      // the set-wins rule would leave it pending behind its own claim.
      level_set_s  = s2_q & ~EDGE_MASK & ~(inservice_q | claim_bits_s);
      w1c_s        = (wr_s && (addr_s == ADDR_PENDING)) ? reg_wdata[NUM_SRC-1:0] : ZERO_SRC;

      // Set events win over claim-clear and W1C on the same edge.
      pending_d = (pending_q & ~(claim_bits_s | w1c_s)) | edge_set_s | level_set_s;

      enable_d = (wr_s && (addr_s == ADDR_ENABLE)) ? reg_wdata[NUM_SRC-1:0] : enable_q;

      // Claim and complete are mutually exclusive: a claim needs inservice
      // empty, a complete needs it occupied.
      if (complete_s) begin
         inservice_d = ZERO_SRC;
         claim_d     = 5'd0;
      end else if (claim_fire_s) begin
         inservice_d = win_onehot_s;
         claim_d     = win_id_s;
      end else begin
         inservice_d = inservice_q;
         claim_d     = claim_q;
      end
   end

   // Read mux: combinational from registers, zero unless a read is presented.
   always_comb begin
      reg_rdata = 32'd0;
      if (rst_n && reg_valid && !reg_we) begin
         case (addr_s)
            ADDR_PENDING:   reg_rdata = 32'(pending_q);
            ADDR_ENABLE:    reg_rdata = 32'(enable_q);
            ADDR_CLAIM:     reg_rdata = 32'(claim_q);
            ADDR_INSERVICE: reg_rdata = 32'(inservice_q);
            default:        reg_rdata = 32'd0;
         endcase
      end else begin
         reg_rdata = 32'd0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= ZERO_SRC;
         s2_q        <= ZERO_SRC;
         s3_q        <= ZERO_SRC;
         ack_q       <= 1'b0;
         warm_q      <= 2'd0;
         pending_q   <= ZERO_SRC;
         enable_q    <= ZERO_SRC;
         inservice_q <= ZERO_SRC;
         claim_q     <= 5'd0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         ack_q       <= ack_d;
         warm_q      <= warm_d;
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         inservice_q <= inservice_d;
         claim_q     <= claim_d;
      end
   end

endmodule

// File: tb/tb_qar_irq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for qar_irq_ctrl (NUM_SRC=8, bit 0 level, bits 1..7 edge).
// Directed steps follow the controller's documented scenarios, then a random
// phase is checked against a behavioural model that works from the sampled
// history of src_irq and the register-level rules.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_qar_irq_ctrl;

   localparam int         N    = 8;
   localparam logic [7:0] EDGE = 8'hFE;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  src_irq;
   logic        reg_valid;
   logic        reg_we;
   logic [31:0] reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_ready;
   logic [31:0] reg_rdata;
   logic        irq_external;
   logic        irq_external_ack;

   int checks   = 0;
   int failures = 0;

   qar_irq_ctrl #(.NUM_SRC(N), .EDGE_MASK(EDGE)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .src_irq          (src_irq),
      .reg_valid        (reg_valid),
      .reg_we           (reg_we),
      .reg_addr         (reg_addr),
      .reg_wdata        (reg_wdata),
      .reg_ready        (reg_ready),
      .reg_rdata        (reg_rdata),
      .irq_external     (irq_external),
      .irq_external_ack (irq_external_ack)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] m_pend  = 8'd0;
   logic [7:0] m_en    = 8'd0;
   logic [7:0] m_ins   = 8'd0;
   logic [4:0] m_claim = 5'd0;
   logic       m_ack   = 1'b0;
   logic [7:0] m_hist[$];          // src samples taken at post-reset edges, newest first
   logic [7:0] n_pend, n_en, n_ins, n_sample;
   logic [4:0] n_claim;
   logic       n_ack, n_clear;

   function automatic logic m_irq();
      return rst_n && ((m_pend & m_en) != 8'd0) && (m_ins == 8'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] off);
      if (!rst_n) return 32'd0;
      case (off)
         3'd0:    return {24'd0, m_pend};
         3'd1:    return {24'd0, m_en};
         3'd2:    return {27'd0, m_claim};
         3'd4:    return {24'd0, m_ins};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      logic       wr, fire, cpl;
      logic [2:0] a;
      logic [7:0] elig, cbit, s2, s3, eset, lset, w1c;
      int         win;
      n_sample = src_irq;
      if (!rst_n) begin
         n_pend = 8'd0; n_en = 8'd0; n_ins = 8'd0; n_claim = 5'd0; n_ack = 1'b0;
         n_clear = 1'b1;
      end else begin
         n_clear = 1'b0;
         wr   = reg_valid && reg_we;
         a    = reg_addr[4:2];
         elig = m_pend & m_en;
         fire = irq_external_ack && !m_ack && m_irq();
         win  = -1;
         cbit = 8'd0;
         if (fire) begin
            for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
            cbit[win] = 1'b1;
         end
         // The request path sees src two edges late; an edge needs the sample
         // three edges back too, and only samples taken since reset count.
         s2 = 8'd0; s3 = 8'd0; eset = 8'd0;
         if (m_hist.size() >= 2) s2 = m_hist[1];
         if (m_hist.size() >= 3) begin
            s3   = m_hist[2];
            eset = s2 & ~s3 & EDGE;
         end
         lset   = s2 & ~EDGE & ~(m_ins | cbit);
         w1c    = (wr && a == 3'd0) ? reg_wdata[7:0] : 8'd0;
         n_pend = (m_pend & ~(cbit | w1c)) | eset | lset;
         n_en   = (wr && a == 3'd1) ? reg_wdata[7:0] : m_en;
         cpl    = wr && a == 3'd3 && m_claim != 5'd0 && reg_wdata == {27'd0, m_claim};
         if (cpl) begin
            n_ins = 8'd0; n_claim = 5'd0;
         end else if (fire) begin
            n_ins = cbit; n_claim = 5'(win + 1);
         end else begin
            n_ins = m_ins; n_claim = m_claim;
         end
         n_ack = irq_external_ack;
      end
   endtask

   // One clock edge: model computed from the inputs in force, then committed.
   task automatic tick();
      model_edge();
      @(posedge clk);
      m_pend = n_pend; m_en = n_en; m_ins = n_ins; m_claim = n_claim; m_ack = n_ack;
      if (n_clear) m_hist.delete();
      else begin
         m_hist.push_front(n_sample);
         if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [2:0] off, input logic [31:0] data);
      reg_valid = 1'b1; reg_we = 1'b1;
      reg_addr  = {27'd0, off, 2'b00};
      reg_wdata = data;
      tick();
      reg_valid = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
      reg_valid = 1'b1; reg_we = 1'b0;
      reg_addr  = {27'd0, off, 2'b00};
      #0.5;
      chk(tag, reg_rdata, exp);
      chk({tag, "_rdy"}, {31'd0, reg_ready}, 32'd1);
      reg_valid = 1'b0;
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      chk(tag, {31'd0, irq_external}, {31'd0, exp});
   endtask

   task automatic ack_pulse();
      irq_external_ack = 1'b1;
      tick();
      irq_external_ack = 1'b0;
   endtask

   // Bound on total run time.
   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] off;
      int         op;
      rst_n = 1'b0; src_irq = 8'hFF; reg_valid = 1'b0; reg_we = 1'b0;
      reg_addr = 32'd0; reg_wdata = 32'd0; irq_external_ack = 1'b0;

      // ---- reset with all sources high ----
      tick(); tick();
      wr_reg(3'd1, 32'h0000_00FF);          // ignored: reset wins
      chk_irq("rst_irq", 1'b0);
      for (int i = 0; i < 8; i++) rd_chk("rst_rd", 3'(i), 32'd0);
      rst_n = 1'b1;
      wr_reg(3'd1, 32'h0000_00FF);
      for (int i = 0; i < 5; i++) tick();
      rd_chk("rst_pend_level_only", 3'd0, 32'h01);  // only the level source pends
      rd_chk("rst_claim", 3'd2, 32'd0);
      chk_irq("rst_irq_level", 1'b1);
      src_irq = 8'h00;
      tick(); tick(); tick();
      wr_reg(3'd0, 32'h0000_00FF);
      rd_chk("rst_pend_clr", 3'd0, 32'd0);
      chk_irq("rst_irq_clr", 1'b0);

      // ---- single edge source, latency and claim/complete ----
      wr_reg(3'd1, 32'h04);
      src_irq = 8'h04;
      tick(); chk_irq("lat_e0", 1'b0);
      tick(); chk_irq("lat_e1", 1'b0);
      src_irq = 8'h00;
      tick(); chk_irq("lat_e2", 1'b1);
      ack_pulse();
      chk_irq("ack_drop", 1'b0);
      rd_chk("claim3", 3'd2, 32'd3);
      rd_chk("pend0", 3'd0, 32'd0);
      rd_chk("insvc4", 3'd4, 32'h04);
      tick();
      wr_reg(3'd3, 32'd3);
      rd_chk("claim_done", 3'd2, 32'd0);
      rd_chk("insvc_done", 3'd4, 32'd0);
      chk_irq("irq_done", 1'b0);

      // ---- two simultaneous sources, priority and throughput ----
      wr_reg(3'd1, 32'hFF);
      src_irq = 8'h22;
      tick(); tick();
      src_irq = 8'h00;
      tick();
      chk_irq("two_irq", 1'b1);
      rd_chk("two_pend", 3'd0, 32'h22);
      ack_pulse();
      rd_chk("two_claim2", 3'd2, 32'd2);
      chk_irq("two_hold0", 1'b0);
      tick();
      chk_irq("two_hold1", 1'b0);
      rd_chk("two_pend_left", 3'd0, 32'h20);
      wr_reg(3'd3, 32'd2);
      chk_irq("two_reraise", 1'b1);
      ack_pulse();
      rd_chk("two_claim6", 3'd2, 32'd6);
      wr_reg(3'd3, 32'd6);
      rd_chk("two_claim_done", 3'd2, 32'd0);
      chk_irq("two_idle", 1'b0);

      // ---- level source re-pend ----
      src_irq = 8'h01;
      tick(); tick(); tick();
      chk_irq("lvl_irq", 1'b1);
      ack_pulse();
      rd_chk("lvl_claim1", 3'd2, 32'd1);
      rd_chk("lvl_pend_claimed", 3'd0, 32'd0);
      tick();
      rd_chk("lvl_pend_insvc", 3'd0, 32'd0);
      wr_reg(3'd3, 32'd1);
      chk_irq("lvl_cpl_edge", 1'b0);
      tick();
      rd_chk("lvl_repend", 3'd0, 32'h01);
      chk_irq("lvl_reraise", 1'b1);
      ack_pulse();
      rd_chk("lvl_claim1b", 3'd2, 32'd1);
      src_irq = 8'h00;
      tick(); tick(); tick();
      wr_reg(3'd3, 32'd1);
      tick(); tick();
      rd_chk("lvl_no_repend", 3'd0, 32'd0);
      chk_irq("lvl_no_reraise", 1'b0);

      // ---- W1C colliding with a new edge on bit 3 ----
      wr_reg(3'd1, 32'h00);
      src_irq = 8'h08;
      tick(); tick();
      src_irq = 8'h00;
      tick(); tick(); tick();
      rd_chk("col_pend_pre", 3'd0, 32'h08);
      src_irq = 8'h08;
      tick(); tick();
      src_irq = 8'h00;
      wr_reg(3'd0, 32'h08);                 // lands on the same edge as the set
      rd_chk("col_set_wins", 3'd0, 32'h08);
      tick(); tick();
      wr_reg(3'd0, 32'h08);
      rd_chk("col_w1c", 3'd0, 32'd0);

      // ---- ack with ENABLE=0 ----
      src_irq = 8'h08;
      tick(); tick();
      src_irq = 8'h00;
      tick(); tick();
      ack_pulse();
      rd_chk("noen_claim", 3'd2, 32'd0);
      rd_chk("noen_insvc", 3'd4, 32'd0);
      rd_chk("noen_pend", 3'd0, 32'h08);
      chk_irq("noen_irq", 1'b0);
      wr_reg(3'd0, 32'h08);

      // ---- reset mid-claim ----
      wr_reg(3'd1, 32'h10);
      src_irq = 8'h10;
      tick(); tick();
      src_irq = 8'h00;
      tick();
      ack_pulse();
      rd_chk("mid_insvc", 3'd4, 32'h10);
      rd_chk("mid_claim", 3'd2, 32'd5);
      irq_external_ack = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      irq_external_ack = 1'b0;
      chk_irq("mid_irq", 1'b0);
      rd_chk("mid_claim0", 3'd2, 32'd0);
      rd_chk("mid_insvc0", 3'd4, 32'd0);
      rd_chk("mid_en0", 3'd1, 32'd0);
      tick();

      // ---- randomized traffic against the model ----
      for (int cyc = 0; cyc < 500; cyc++) begin
         if ($urandom_range(0, 3) == 0) src_irq = 8'($urandom);
         if ($urandom_range(0, 2) == 0) irq_external_ack = ~irq_external_ack;
         off = 3'($urandom_range(0, 7));
         rd_chk("rnd_rd", off, m_read(off));
         chk_irq("rnd_irq", m_irq());
         rst_n = ($urandom_range(0, 99) != 0);
         op = $urandom_range(0, 9);
         reg_valid = 1'b0; reg_we = 1'b0;
         if (op >= 4) begin
            reg_valid = 1'b1; reg_we = 1'b1;
            reg_wdata = $urandom;
            case (op)
               4:       off = 3'd1;
               5:       off = 3'd0;
               6:       begin off = 3'd3; reg_wdata = {27'd0, m_claim}; end
               7:       begin off = 3'd3; reg_wdata = 32'($urandom_range(0, 9)); end
               default: off = 3'($urandom_range(2, 7));
            endcase
            reg_addr = {27'd0, off, 2'b00};
         end
         tick();
         reg_valid = 1'b0; reg_we = 1'b0;
         rst_n = 1'b1;
      end
      for (int i = 0; i < 8; i++) rd_chk("end_rd", 3'(i), m_read(3'(i)));
      chk_irq("end_irq", m_irq());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
